// File: rtl/led_pwm_driver_pkg.sv
// rtl/led_pwm_driver_pkg.sv - shared widths, constants and duty saturation helper
//
// Purpose : common constants for the LED PWM driver slice.
// Contents: LED_W, PWM_BITS, PWM_STEPS, DUTY_W, DUTY_FULL, PWM_MAX, sat_duty().
package led_pwm_driver_pkg;

    localparam int LED_W     = 8;
    localparam int PWM_BITS  = 4;
    localparam int PWM_STEPS = 16;
    localparam int DUTY_W    = 5;

    localparam logic [DUTY_W-1:0]   DUTY_FULL = DUTY_W'(16);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = PWM_BITS'(PWM_STEPS - 1);

    // Anything above full scale behaves as fully on, so clamp once at load time.
    function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] d);
        return (d > DUTY_FULL) ? DUTY_FULL : d;
    endfunction

endpackage

// File: rtl/led_pwm_driver_if.sv
// rtl/led_pwm_driver_if.sv - LED register-side inputs and pin-side outputs of the PWM driver
//
// Purpose : groups the LED data/brightness/blink inputs and the LED drive outputs.
// Signals : led_value[8], duty[5], blink_mask[8]  (master -> slave)
//           led_out[8], frame_start               (slave -> master)
// Modports: master (register bus side / testbench), slave (led_pwm_driver).
interface led_pwm_driver_if;
    import led_pwm_driver_pkg::*;

    logic [LED_W-1:0]  led_value;
    logic [DUTY_W-1:0] duty;
    logic [LED_W-1:0]  blink_mask;
    logic [LED_W-1:0]  led_out;
    logic              frame_start;

    modport master (
        output led_value, duty, blink_mask,
        input  led_out, frame_start
    );

    modport slave (
        input  led_value, duty, blink_mask,
        output led_out, frame_start
    );

endinterface

// File: rtl/led_pwm_driver_prescaler.sv
// rtl/led_pwm_driver_prescaler.sv - divide-by-PRESCALE counter producing a one-cycle step pulse
//
// Purpose : module led_prescaler; counts 0..PRESCALE-1 and wraps.
// Ports   : clk   in  clock
//           reset in  asynchronous, active-high
//           step  out high for the single cycle in which the count equals PRESCALE-1
module led_prescaler #(
    parameter int PRESCALE = 50
) (
    input  logic clk,
    input  logic reset,
    output logic step
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] presc_cnt;

    // With PRESCALE = 1 the counter sits at 0 and step is permanently high.
    assign step = (presc_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
        end else if (step) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - frame-shadowed, PWM-dimmed, optionally blinking LED pin driver
//
// Purpose : latches LED value, duty and blink mask once per 16-step PWM frame and drives
//           registered LED outputs. Blink support is built only when the macro
//           LED_PWM_DRIVER_BLINK_EN is defined; otherwise blink_mask is ignored.
// Ports   : clk   in  clock
//           reset in  asynchronous, active-high
//           bus   led_pwm_driver_if.slave (led_value, duty, blink_mask in; led_out, frame_start out)
module led_pwm_driver
    import led_pwm_driver_pkg::*;
#(
    parameter int PRESCALE     = 50,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    led_pwm_driver_if.slave       bus
);

    logic                step;
    logic                boundary;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [LED_W-1:0]    sh_value;
    logic [DUTY_W-1:0]   sh_duty;
    logic                blink_phase;
    logic [LED_W-1:0]    blank;
    logic                pwm_on;
    logic [LED_W-1:0]    led_out_q;
    logic                frame_start_q;

    led_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .step  (step)
    );

    assign boundary = step && (pwm_cnt == PWM_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else if (step) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);   // natural 15 -> 0 wrap
        end
    end

    // Shadows only move on the frame boundary so a frame is always rendered from one
    // consistent snapshot of the register inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_value <= '0;
            sh_duty  <= '0;
        end else if (boundary) begin
            sh_value <= bus.led_value;
            sh_duty  <= sat_duty(bus.duty);
        end
    end

`ifdef LED_PWM_DRIVER_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0]    frame_cnt;
    logic [LED_W-1:0] sh_mask;

    // The phase toggles on the same edge as the shadow load, so the first output
    // cycle of a frame sees both the new snapshot and the new phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            sh_mask     <= '0;
        end else if (boundary) begin
            sh_mask <= bus.blink_mask;
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    assign blank = sh_mask & {LED_W{blink_phase}};
`else
    assign blink_phase = 1'b0;
    assign blank       = {LED_W{blink_phase}};
`endif

    // Zero-extended compare so sh_duty = 16 is on for every step.
    assign pwm_on = ({1'b0, pwm_cnt} < sh_duty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_out_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            led_out_q     <= sh_value & {LED_W{pwm_on}} & ~blank;
            frame_start_q <= boundary;
        end
    end

    assign bus.led_out     = led_out_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - self-checking bench for led_pwm_driver against a frame-arithmetic model
module tb_led_pwm_driver;

    localparam int P  = 2;
    localparam int BF = 2;
    localparam int F  = 16 * P;

`ifdef LED_PWM_DRIVER_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    led_pwm_driver_if bus ();

    led_pwm_driver #(
        .PRESCALE     (P),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Edges since reset release, and the snapshot the model believes is in force.
    int         t = 0;
    logic [7:0] in_val, in_mask;
    int         in_duty;
    logic [7:0] m_val, m_mask;
    int         m_duty;

    // Expected led_out right after edge tt: the PWM step and frame number are plain
    // divisions of the elapsed cycle count before that edge.
    function automatic logic [7:0] exp_led(int tt, logic [7:0] val, int duty, logic [7:0] mask);
        int         step_idx;
        int         frames;
        int         d;
        bit         phase;
        logic [7:0] v;
        step_idx = ((tt - 1) / P) % 16;
        frames   = (tt - 1) / F;
        d        = (duty > 16) ? 16 : duty;
        phase    = BLINK_EN && (((frames / BF) % 2) == 1);
        v        = (step_idx < d) ? val : 8'h00;
        if (phase) v = v & ~mask;
        return v;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, expv);
        end
    endtask

    task automatic set_in(input logic [7:0] v, input int d, input logic [7:0] m);
        in_val         = v;
        in_duty        = d;
        in_mask        = m;
        bus.led_value  = v;
        bus.duty       = 5'(d);
        bus.blink_mask = m;
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        #1;
        check("led_out", bus.led_out, exp_led(t, m_val, m_duty, m_mask));
        check("frame_start", {7'b0, bus.frame_start}, ((t % F) == 0) ? 8'd1 : 8'd0);
        if ((t % F) == 0) begin
            m_val  = in_val;
            m_duty = in_duty;
            m_mask = in_mask;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_clear();
        t      = 0;
        m_val  = 8'h00;
        m_duty = 0;
        m_mask = 8'h00;
    endtask

    initial begin
        // Reset: inputs fully on while reset is held; outputs must stay low.
        set_in(8'hFF, 16, 8'h00);
        model_clear();
        repeat (3) @(negedge clk);
        check("reset_led_out", bus.led_out, 8'h00);
        check("reset_frame_start", {7'b0, bus.frame_start}, 8'h00);
        reset = 1'b0;
        run(2 * F);

        // Full duty: A5 for every cycle once loaded.
        set_in(8'hA5, 16, 8'h00);
        run(3 * F);

        // Quarter duty, then over-range duty that saturates to full.
        set_in(8'hFF, 4, 8'h00);
        run(2 * F);
        set_in(8'hFF, 31, 8'h00);
        run(2 * F);

        // Duty 0 is fully off.
        set_in(8'hFF, 0, 8'h00);
        run(F);

        // Mid-frame write: 0F held across a full frame, then F0 written at cycle 10.
        set_in(8'h0F, 16, 8'h00);
        while ((t % F) != 0) tick();
        run(F);
        while ((t % F) != 10) tick();
        set_in(8'hF0, 16, 8'h00);
        run(2 * F);

        // Blink on the low nibble.
        set_in(8'hFF, 16, 8'h0F);
        run(6 * F);

        // Randomised inputs changing at arbitrary cycles.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_in(8'($urandom), int'($urandom_range(0, 31)), 8'($urandom));
            tick();
        end

        // Reset at cycle 13 of a frame: outputs clear at once, timing restarts.
        set_in(8'hFF, 16, 8'h00);
        while ((t % F) != 0) tick();
        run(F);
        while ((t % F) != 13) tick();
        check("pre_reset_led_out", bus.led_out, 8'hFF);
        reset = 1'b1;
        #1;
        check("async_reset_led_out", bus.led_out, 8'h00);
        check("async_reset_frame_start", {7'b0, bus.frame_start}, 8'h00);
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run(3 * F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
